// File: rtl/display_power_pkg.sv
// display_power_pkg
// Shared definitions for the display power sequencer:
//   - seq_state_t : 3-bit sequencer state encoding, also exported on o_seq_state
//   - DEF_T_*     : default datasheet gaps in i_master_clk cycles
//   - PWM_W       : backlight PWM counter / level width
package display_power_pkg;

    typedef enum logic [2:0] {
        ST_OFF        = 3'd0,
        ST_VDD_UP     = 3'd1,
        ST_VIDEO_UP   = 3'd2,
        ST_ON         = 3'd3,
        ST_BL_DOWN    = 3'd4,
        ST_VIDEO_DOWN = 3'd5,
        ST_VDD_OFF    = 3'd6
    } seq_state_t;

    localparam int unsigned DEF_T_VDD_TO_VIDEO     = 1000;
    localparam int unsigned DEF_T_VIDEO_TO_BL      = 2000;
    localparam int unsigned DEF_T_BL_TO_VIDEO_OFF  = 2000;
    localparam int unsigned DEF_T_VIDEO_OFF_TO_VDD = 1000;
    localparam int unsigned DEF_T_MIN_OFF          = 5000;
    localparam int unsigned DEF_CNT_WIDTH          = 24;

    localparam int unsigned PWM_W = 8;

endpackage

// File: rtl/display_power_sequencer_backlight_pwm.sv
// backlight_pwm
// Backlight PWM generator, only built when BACKLIGHT_PWM_EN is defined.
// An 8-bit free-running counter sets the period; the level is sampled once
// per period (counter at 0) so a level change never produces a runt pulse.
// Ports:
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset
//   en_i    : backlight allowed this cycle (sequencer's next state is ON)
//   level_i : requested duty, 0 = dark, 255 = fully on
//   pwm_o   : registered PWM output
`ifdef BACKLIGHT_PWM_EN
module backlight_pwm
    import display_power_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [PWM_W-1:0] level_i,
    output logic             pwm_o
);

    localparam logic [PWM_W-1:0] PWM_MAX = '1;

    logic [PWM_W-1:0] cnt_q;
    logic [PWM_W-1:0] level_q;
    logic             pwm_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            level_q <= '0;
            pwm_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == '0) begin
                level_q <= level_i;
            end
            // Full-scale level must stay solidly on; a plain compare would
            // drop one cycle per period at cnt=255.
            pwm_q <= en_i & ((level_q == PWM_MAX) | (cnt_q < level_q));
        end
    end

    assign pwm_o = pwm_q;

endmodule
`endif

// File: rtl/display_power_sequencer.sv
// display_power_sequencer
// Turns the level request i_display_request into a timed panel power-up
// (VDD -> video run -> backlight) or power-down (backlight -> video run ->
// VDD -> minimum off time). Power-down and the minimum off time are never
// aborted; a new request is only taken from OFF.
// Optional feature: define BACKLIGHT_PWM_EN to drive o_backlight_en from a
// PWM generator controlled by i_backlight_level (port absent otherwise).
// Ports:
//   i_master_clk      : system clock, single domain
//   i_reset_n         : asynchronous active-low reset
//   i_display_request : display-on request, already in i_master_clk domain
//   i_backlight_level : backlight duty (BACKLIGHT_PWM_EN only)
//   o_panel_vdd_en    : panel supply enable
//   o_video_run       : video timing generator enable
//   o_backlight_en    : backlight enable / PWM
//   o_display_ready   : display fully up (state ON)
//   o_seq_state       : current state encoding
module display_power_sequencer
    import display_power_pkg::*;
#(
    parameter int unsigned T_VDD_TO_VIDEO     = DEF_T_VDD_TO_VIDEO,
    parameter int unsigned T_VIDEO_TO_BL      = DEF_T_VIDEO_TO_BL,
    parameter int unsigned T_BL_TO_VIDEO_OFF  = DEF_T_BL_TO_VIDEO_OFF,
    parameter int unsigned T_VIDEO_OFF_TO_VDD = DEF_T_VIDEO_OFF_TO_VDD,
    parameter int unsigned T_MIN_OFF          = DEF_T_MIN_OFF,
    parameter int unsigned CNT_WIDTH          = DEF_CNT_WIDTH
) (
    input  logic             i_master_clk,
    input  logic             i_reset_n,
    input  logic             i_display_request,
`ifdef BACKLIGHT_PWM_EN
    input  logic [PWM_W-1:0] i_backlight_level,
`endif
    output logic             o_panel_vdd_en,
    output logic             o_video_run,
    output logic             o_backlight_en,
    output logic             o_display_ready,
    output logic [2:0]       o_seq_state
);

    // Counter load values: a state loaded with T-1 exits when the count reads
    // 0, so it lasts exactly T cycles.
    localparam logic [CNT_WIDTH-1:0] LD_VDD_UP     = CNT_WIDTH'(T_VDD_TO_VIDEO - 1);
    localparam logic [CNT_WIDTH-1:0] LD_VIDEO_UP   = CNT_WIDTH'(T_VIDEO_TO_BL - 1);
    localparam logic [CNT_WIDTH-1:0] LD_BL_DOWN    = CNT_WIDTH'(T_BL_TO_VIDEO_OFF - 1);
    localparam logic [CNT_WIDTH-1:0] LD_VIDEO_DOWN = CNT_WIDTH'(T_VIDEO_OFF_TO_VDD - 1);
    localparam logic [CNT_WIDTH-1:0] LD_VDD_OFF    = CNT_WIDTH'(T_MIN_OFF - 1);

    seq_state_t           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 vdd_q, video_q, ready_q;
    logic                 expired;

    assign expired = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = expired ? cnt_q : cnt_q - 1'b1;
        case (state_q)
            ST_OFF: begin
                if (i_display_request) begin
                    state_d = ST_VDD_UP;
                    cnt_d   = LD_VDD_UP;
                end
            end
            // During power-up a dropped request beats a simultaneous expiry.
            ST_VDD_UP: begin
                if (!i_display_request) begin
                    state_d = ST_VDD_OFF;
                    cnt_d   = LD_VDD_OFF;
                end else if (expired) begin
                    state_d = ST_VIDEO_UP;
                    cnt_d   = LD_VIDEO_UP;
                end
            end
            ST_VIDEO_UP: begin
                if (!i_display_request) begin
                    state_d = ST_VIDEO_DOWN;
                    cnt_d   = LD_VIDEO_DOWN;
                end else if (expired) begin
                    state_d = ST_ON;
                end
            end
            ST_ON: begin
                if (!i_display_request) begin
                    state_d = ST_BL_DOWN;
                    cnt_d   = LD_BL_DOWN;
                end
            end
            ST_BL_DOWN: begin
                if (expired) begin
                    state_d = ST_VIDEO_DOWN;
                    cnt_d   = LD_VIDEO_DOWN;
                end
            end
            ST_VIDEO_DOWN: begin
                if (expired) begin
                    state_d = ST_VDD_OFF;
                    cnt_d   = LD_VDD_OFF;
                end
            end
            ST_VDD_OFF: begin
                if (expired) begin
                    state_d = ST_OFF;
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they switch on the same
    // edge as the state register.
    always_ff @(posedge i_master_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            vdd_q   <= 1'b0;
            video_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vdd_q   <= (state_d == ST_VDD_UP)   || (state_d == ST_VIDEO_UP) ||
                       (state_d == ST_ON)       || (state_d == ST_BL_DOWN)  ||
                       (state_d == ST_VIDEO_DOWN);
            video_q <= (state_d == ST_VIDEO_UP) || (state_d == ST_ON) ||
                       (state_d == ST_BL_DOWN);
            ready_q <= (state_d == ST_ON);
        end
    end

`ifdef BACKLIGHT_PWM_EN
    backlight_pwm u_backlight_pwm (
        .clk_i   (i_master_clk),
        .rst_ni  (i_reset_n),
        .en_i    (state_d == ST_ON),
        .level_i (i_backlight_level),
        .pwm_o   (o_backlight_en)
    );
`else
    logic bl_q;

    always_ff @(posedge i_master_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bl_q <= 1'b0;
        end else begin
            bl_q <= (state_d == ST_ON);
        end
    end

    assign o_backlight_en = bl_q;
`endif

    assign o_panel_vdd_en  = vdd_q;
    assign o_video_run     = video_q;
    assign o_display_ready = ready_q;
    assign o_seq_state     = state_q;

endmodule

// File: tb/tb_display_power_sequencer.sv
// tb_display_power_sequencer
// Directed and randomised request sequences for display_power_sequencer with
// short gaps (4/3/2/5/6). A reference model tracks the sequencer phase and
// the absolute edge at which the current phase ends; every cycle the DUT
// outputs are compared against the phase's required output levels.
// With BACKLIGHT_PWM_EN defined the backlight duty is also measured.
module tb_display_power_sequencer;

    localparam int T1   = 4;
    localparam int T2   = 3;
    localparam int T3   = 2;
    localparam int T4   = 5;
    localparam int TMIN = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
`ifdef BACKLIGHT_PWM_EN
    logic [7:0] level = 8'd255;
`endif
    logic       vdd, video, bl, ready;
    logic [2:0] seq_state;

    int n_checks = 0;
    int n_err    = 0;
    int edge_n   = 0;
    int ph       = 0;   // 0 OFF,1 VDD_UP,2 VIDEO_UP,3 ON,4 BL_DOWN,5 VIDEO_DOWN,6 VDD_OFF
    int deadline = 0;   // edge at which the current timed phase ends
    bit bl_exact = 1'b1;

    display_power_sequencer #(
        .T_VDD_TO_VIDEO     (T1),
        .T_VIDEO_TO_BL      (T2),
        .T_BL_TO_VIDEO_OFF  (T3),
        .T_VIDEO_OFF_TO_VDD (T4),
        .T_MIN_OFF          (TMIN),
        .CNT_WIDTH          (8)
    ) dut (
        .i_master_clk      (clk),
        .i_reset_n         (rst_n),
        .i_display_request (req),
`ifdef BACKLIGHT_PWM_EN
        .i_backlight_level (level),
`endif
        .o_panel_vdd_en    (vdd),
        .o_video_run       (video),
        .o_backlight_en    (bl),
        .o_display_ready   (ready),
        .o_seq_state       (seq_state)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    function automatic int dur(input int p);
        case (p)
            1: return T1;
            2: return T2;
            4: return T3;
            5: return T4;
            6: return TMIN;
            default: return 0;
        endcase
    endfunction

    // Advance the model by one clock edge with request r seen at that edge.
    task automatic model_edge(input logic r);
        int  nxt;
        bit  done;
        nxt  = ph;
        done = (edge_n == deadline);
        case (ph)
            0: if (r) nxt = 1;
            1: if (!r) nxt = 6; else if (done) nxt = 2;
            2: if (!r) nxt = 5; else if (done) nxt = 3;
            3: if (!r) nxt = 4;
            4: if (done) nxt = 5;
            5: if (done) nxt = 6;
            6: if (done) nxt = 0;
            default: nxt = 0;
        endcase
        if (nxt != ph) begin
            ph       = nxt;
            deadline = edge_n + dur(nxt);
        end
    endtask

    task automatic compare_all();
        chk("seq_state", 32'(seq_state), 32'(ph));
        chk("vdd_en",    32'(vdd),   32'(ph >= 1 && ph <= 5));
        chk("video_run", 32'(video), 32'(ph >= 2 && ph <= 4));
        chk("ready",     32'(ready), 32'(ph == 3));
        if (bl_exact) chk("backlight", 32'(bl), 32'(ph == 3));
    endtask

    task automatic step(input logic r);
        req = r;
        @(posedge clk);
        edge_n++;
        model_edge(r);
        #1;
        compare_all();
    endtask

    initial begin
        int hi;
        logic r;
        int len;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 32'(seq_state), 32'd0);
        chk("rst_vdd",   32'(vdd),       32'd0);
        chk("rst_video", 32'(video),     32'd0);
        chk("rst_bl",    32'(bl),        32'd0);
        chk("rst_ready", 32'(ready),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef BACKLIGHT_PWM_EN
        // Let the PWM capture level 255 so the backlight is a plain enable.
        repeat (260) step(1'b0);
`endif
        edge_n = 0;

        // Power-up at edge 10, power-down from edge 30
        for (int e = 1; e <= 9; e++) step(1'b0);
        step(1'b1);
        chk("up_vdd_e10", 32'(vdd), 32'd1);
        chk("up_state_e10", 32'(seq_state), 32'd1);
        for (int e = 11; e <= 43; e++) begin
            step(e < 30);
            case (e)
                13: chk("up_video_e13", 32'(video), 32'd0);
                14: begin
                    chk("up_video_e14", 32'(video), 32'd1);
                    chk("up_state_e14", 32'(seq_state), 32'd2);
                end
                16: chk("up_ready_e16", 32'(ready), 32'd0);
                17: begin
                    chk("up_ready_e17", 32'(ready), 32'd1);
                    chk("up_bl_e17", 32'(bl), 32'd1);
                    chk("up_state_e17", 32'(seq_state), 32'd3);
                end
                30: begin
                    chk("dn_ready_e30", 32'(ready), 32'd0);
                    chk("dn_bl_e30", 32'(bl), 32'd0);
                    chk("dn_video_e30", 32'(video), 32'd1);
                end
                32: chk("dn_video_e32", 32'(video), 32'd0);
                36: chk("dn_vdd_e36", 32'(vdd), 32'd1);
                37: chk("dn_vdd_e37", 32'(vdd), 32'd0);
                42: chk("dn_state_e42", 32'(seq_state), 32'd6);
                43: chk("dn_state_e43", 32'(seq_state), 32'd0);
                default: ;
            endcase
        end

        // Drop two cycles into VDD_UP
        step(1'b0);
        step(1'b1);
        step(1'b1);
        step(1'b0);
        chk("abort_vddup_state", 32'(seq_state), 32'd6);
        repeat (5) begin
            step(1'b0);
            chk("abort_vddup_video", 32'(video), 32'd0);
            chk("abort_vddup_hold", 32'(seq_state), 32'd6);
        end
        step(1'b0);
        chk("abort_vddup_off", 32'(seq_state), 32'd0);

        // Drop exactly on VIDEO_UP expiry: drop wins
        step(1'b1);
        repeat (6) step(1'b1);
        chk("vidup_before_drop", 32'(seq_state), 32'd2);
        step(1'b0);
        chk("vidup_drop_state", 32'(seq_state), 32'd5);
        repeat (15) begin
            step(1'b0);
            chk("vidup_drop_bl", 32'(bl), 32'd0);
        end
        chk("vidup_drop_off", 32'(seq_state), 32'd0);

        // Re-raise during BL_DOWN and VDD_OFF
        step(1'b1);
        repeat (7) step(1'b1);
        chk("rr_on", 32'(seq_state), 32'd3);
        step(1'b0);
        chk("rr_bldown", 32'(seq_state), 32'd4);
        step(1'b1);
        chk("rr_bldown_hold", 32'(seq_state), 32'd4);
        step(1'b1);
        chk("rr_viddown", 32'(seq_state), 32'd5);
        repeat (5) step(1'b0);
        chk("rr_vddoff", 32'(seq_state), 32'd6);
        repeat (5) begin
            step(1'b1);
            chk("rr_vddoff_hold", 32'(seq_state), 32'd6);
        end
        step(1'b1);
        chk("rr_off", 32'(seq_state), 32'd0);
        step(1'b1);
        chk("rr_restart", 32'(seq_state), 32'd1);

`ifdef BACKLIGHT_PWM_EN
        // PWM duty in ON
        for (int i = 0; i < 20 && ph != 3; i++) step(1'b1);
        chk("pwm_on", 32'(ready), 32'd1);
        bl_exact = 1'b0;
        level = 8'd64;
        repeat (300) step(1'b1);
        hi = 0;
        repeat (256) begin
            step(1'b1);
            hi += int'(bl);
        end
        chk("pwm_duty64", 32'(hi), 32'd64);
        level = 8'd255;
        repeat (300) step(1'b1);
        hi = 0;
        repeat (256) begin
            step(1'b1);
            hi += int'(bl);
        end
        chk("pwm_duty255", 32'(hi), 32'd256);
        bl_exact = 1'b1;
`endif

        // Randomised request bursts
        r = 1'b0;
        for (int b = 0; b < 24; b++) begin
            r = ~r;
            len = int'($urandom_range(1, 20));
            repeat (len) step(r);
        end

        // Asynchronous reset while ON
        for (int i = 0; i < 30 && ph != 3; i++) step(1'b1);
        chk("rst_on_reached", 32'(seq_state), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(seq_state), 32'd0);
        chk("arst_vdd",   32'(vdd),       32'd0);
        chk("arst_video", 32'(video),     32'd0);
        chk("arst_bl",    32'(bl),        32'd0);
        chk("arst_ready", 32'(ready),     32'd0);
        ph = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0);
        step(1'b1);
        chk("post_rst_up", 32'(seq_state), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/display_power_sequencer.md
# display_power_sequencer

Sequences panel power, video timing run and backlight for the attached display, in the order and with the gaps the panel datasheet requires. Sits between the system controller's video-enable output and the panel I/O pins and video timing generator. Turns a single level request into a timed power-up or power-down sequence and reports when the display is fully up.

## Interface
- `T_VDD_TO_VIDEO`, default 1000: cycles from VDD on to video run on; must be ≥1.
- `T_VIDEO_TO_BL`, default 2000: cycles from video run on to backlight on; must be ≥1.
- `T_BL_TO_VIDEO_OFF`, default 2000: cycles from backlight off to video run off; must be ≥1.
- `T_VIDEO_OFF_TO_VDD`, default 1000: cycles from video run off to VDD off; must be ≥1.
- `T_MIN_OFF`, default 5000: minimum cycles VDD stays off before the next power-up; must be ≥1.
- `CNT_WIDTH`, default 24: delay counter width; must hold the largest `T_*` − 1.
- `i_master_clk  in  1  system clock; single clock domain.`
- `i_reset_n  in  1  asynchronous, active-low reset.`
- `i_display_request  in  1  level request for the display on; synchronous to i_master_clk.`
- `i_backlight_level  in  8  backlight duty level; present only with BACKLIGHT_PWM_EN.`
- `o_panel_vdd_en  out  1  panel supply enable.`
- `o_video_run  out  1  enables the video timing generator.`
- `o_backlight_en  out  1  backlight enable, or PWM output with BACKLIGHT_PWM_EN.`
- `o_display_ready  out  1  high only in state ON.`
- `o_seq_state  out  3  current state encoding, for the status controller.`

## Operation
- States and encodings: OFF=0, VDD_UP=1, VIDEO_UP=2, ON=3, BL_DOWN=4, VIDEO_DOWN=5, VDD_OFF=6.
- One down-counter. It is loaded with `T_x`−1 on entry to each timed state. The state exits on the cycle the counter reads 0, so each timed state lasts exactly `T_x` cycles.
- OFF: exits to VDD_UP when `i_display_request`=1.
- VDD_UP (`T_VDD_TO_VIDEO`): exits to VIDEO_UP when the count expires. If the request drops first, exits to VDD_OFF.
- VIDEO_UP (`T_VIDEO_TO_BL`): exits to ON when the count expires. If the request drops first, exits to VIDEO_DOWN.
- ON: exits to BL_DOWN when the request is 0.
- BL_DOWN (`T_BL_TO_VIDEO_OFF`): exits to VIDEO_DOWN on expiry.
- VIDEO_DOWN (`T_VIDEO_OFF_TO_VDD`): exits to VDD_OFF on expiry.
- VDD_OFF (`T_MIN_OFF`): exits to OFF on expiry.
- Power-down and min-off are never aborted. A request that rises during them is honoured only from OFF.
- If a request drop and a count expiry occur in the same cycle in VDD_UP or VIDEO_UP, the drop wins.
- Output decode:
  - `o_panel_vdd_en` = 1 in VDD_UP through VIDEO_DOWN.
  - `o_video_run` = 1 in VIDEO_UP, ON and BL_DOWN.
  - Backlight is active in ON only.
  - `o_display_ready` = (state==ON).
- Reset values: state OFF, counter 0, all outputs 0, `o_seq_state`=0. Reset mid-sequence drops every output to 0 immediately and asynchronously. No delays are honoured.

## Timing
- All outputs are registered. They are decoded from the next state and change on the same edge as the state.
- Request high at the setup of edge N:
  - `o_panel_vdd_en`=1 after edge N.
  - `o_video_run`=1 after edge N+`T_VDD_TO_VIDEO`.
  - Backlight and ready=1 after edge N+`T_VDD_TO_VIDEO`+`T_VIDEO_TO_BL`.
- Request low at edge M while in ON:
  - Backlight and ready=0 after edge M.
  - Video run=0 after M+`T_BL_TO_VIDEO_OFF`.
  - VDD=0 after M+`T_BL_TO_VIDEO_OFF`+`T_VIDEO_OFF_TO_VDD`.
  - OFF is reached `T_MIN_OFF` cycles after that.
- The request is not synchronised internally. The source must be in the `i_master_clk` domain.

## Configuration
- `BACKLIGHT_PWM_EN` defined:
  - An 8-bit free-running counter runs in every state.
  - `i_backlight_level` is captured only when the counter is 0.
  - In ON, `o_backlight_en` = (cnt < level), except level 255 gives constant 1 and level 0 gives constant 0.
  - Outside ON the output is forced 0 within one cycle.
- `BACKLIGHT_PWM_EN` undefined: the `i_backlight_level` port is absent, and `o_backlight_en` is a static 1 in ON.

## Structure
- Shared package `display_power_pkg` holds:
  - the state encoding constants (3-bit);
  - the default `T_*` values;
  - the PWM width constant.
- One sub-module, `backlight_pwm` (counter, level capture, compare), is instantiated only under `BACKLIGHT_PWM_EN`. The sequencer FSM and counter stay in the top module.

## Test plan
- Bench parameters: T1=4, T2=3, T3=2, T4=5, TMIN=6.
- Raise the request at edge 10 and hold it:
  - VDD rises after edge 10.
  - Video run rises after edge 14.
  - Backlight and ready rise after edge 17.
  - `o_seq_state` goes 1, 2, 3.
- From ON, drop the request at edge 30:
  - Backlight and ready fall after edge 30.
  - Video run falls after edge 32.
  - VDD falls after edge 37.
  - State returns to 0 after edge 43.
- Drop the request 2 cycles into VDD_UP: state goes to 6, video never rises, and OFF is reached 6 cycles later.
- Drop the request in VIDEO_UP on its expiry cycle: the state goes to 5, not 3, and the backlight never rises.
- Re-raise the request during BL_DOWN and VDD_OFF: the full power-down completes, then power-up starts from OFF on the next edge.
- Assert reset while in ON: all outputs are 0 asynchronously. With `BACKLIGHT_PWM_EN` and level 64 in ON, the duty is 64/256 per period; level 255 gives constant 1.
